mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 159 +++++++++++++++
 tb/tb_mem_arbiter.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: round-robin between a core LSU and a debug/loader
// port, with per-owner bus locking and fixed-latency read-response routing.
module mem_arbiter #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned RD_LAT   = 1,
    parameter int unsigned MAX_LOCK = 8
) (
    input  logic              i_clk,
    input  logic              i_reset,

    input  logic              i_m0_req,
    input  logic [ADDR_W-1:0] i_m0_addr,
    input  logic [DATA_W-1:0] i_m0_wdata,
    input  logic [3:0]        i_m0_bmask,
    input  logic              i_m0_wren,
    input  logic              i_m0_lock,
    output logic              o_m0_gnt,
    output logic              o_m0_rvalid,
    output logic [DATA_W-1:0] o_m0_rdata,

    input  logic              i_m1_req,
    input  logic [ADDR_W-1:0] i_m1_addr,
    input  logic [DATA_W-1:0] i_m1_wdata,
    input  logic [3:0]        i_m1_bmask,
    input  logic              i_m1_wren,
    input  logic              i_m1_lock,
    output logic              o_m1_gnt,
    output logic              o_m1_rvalid,
    output logic [DATA_W-1:0] o_m1_rdata,

    output logic              o_mem_en,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    output logic [3:0]        o_mem_bmask,
    output logic              o_mem_wren,
    input  logic [DATA_W-1:0] i_mem_rdata,

    output logic              o_busy
);

    localparam int unsigned CNT_W = $clog2(MAX_LOCK + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_OWN0 = 2'd1;
    localparam logic [1:0] ST_OWN1 = 2'd2;

    // Counter value at which the current locked grant is the last one allowed.
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(MAX_LOCK - 1);

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              rr_q, rr_d;
    logic [RD_LAT-1:0] pv_q, pv_d;
    logic [RD_LAT-1:0] pid_q, pid_d;

    logic gnt0_c;
    logic gnt1_c;
    logic wren_c;
    logic rd_push_c;
    logic rsp_c;
    logic rsp_id_c;

    // Grant selection and ownership tracking; rr_q holds the last winner.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rr_d    = rr_q;
        gnt0_c  = 1'b0;
        gnt1_c  = 1'b0;

        case (state_q)
            ST_OWN0: begin
                gnt0_c = i_m0_req;
                if (!i_m0_req || !i_m0_lock || (cnt_q >= LOCK_LAST)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_OWN1: begin
                gnt1_c = i_m1_req;
                if (!i_m1_req || !i_m1_lock || (cnt_q >= LOCK_LAST)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                gnt0_c = i_m0_req && (!i_m1_req || rr_q);
                gnt1_c = i_m1_req && !gnt0_c;
                // A single permitted locked cycle releases on the spot.
                if ((MAX_LOCK > 1) && ((gnt0_c && i_m0_lock) || (gnt1_c && i_m1_lock))) begin
                    state_d = gnt1_c ? ST_OWN1 : ST_OWN0;
                    cnt_d   = CNT_W'(1);
                end
            end
        endcase

        if (!i_reset) begin
            gnt0_c = 1'b0;
            gnt1_c = 1'b0;
        end

        if (gnt0_c) begin
            rr_d = 1'b0;
        end else if (gnt1_c) begin
            rr_d = 1'b1;
        end
    end

    assign wren_c    = (gnt0_c & i_m0_wren) | (gnt1_c & i_m1_wren);
    assign rd_push_c = (gnt0_c | gnt1_c) & ~wren_c;

    // Read-return pipeline: valid bit and owner id shift one slot per cycle.
    always_comb begin
        pv_d     = pv_q << 1;
        pid_d    = pid_q << 1;
        pv_d[0]  = rd_push_c;
        pid_d[0] = gnt1_c;
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rr_q    <= 1'b1;
            pv_q    <= '0;
            pid_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rr_q    <= rr_d;
            pv_q    <= pv_d;
            pid_q   <= pid_d;
        end
    end

    assign rsp_c    = pv_q[RD_LAT-1];
    assign rsp_id_c = pid_q[RD_LAT-1];

    assign o_m0_gnt    = gnt0_c;
    assign o_m1_gnt    = gnt1_c;
    assign o_m0_rvalid = rsp_c & ~rsp_id_c;
    assign o_m1_rvalid = rsp_c & rsp_id_c;
    assign o_m0_rdata  = (rsp_c && !rsp_id_c) ? i_mem_rdata : '0;
    assign o_m1_rdata  = (rsp_c && rsp_id_c) ? i_mem_rdata : '0;

    assign o_mem_en    = gnt0_c | gnt1_c;
    assign o_mem_wren  = wren_c;
    assign o_mem_addr  = gnt1_c ? i_m1_addr  : (gnt0_c ? i_m0_addr  : '0);
    assign o_mem_wdata = gnt1_c ? i_m1_wdata : (gnt0_c ? i_m0_wdata : '0);
    assign o_mem_bmask = gnt1_c ? i_m1_bmask : (gnt0_c ? i_m0_bmask : '0);

    assign o_busy = (|pv_q) | (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (RD_LAT=1/MAX_LOCK=8 and RD_LAT=2/MAX_LOCK=3)
// share stimulus; each is compared against its own transaction-level reference model.
module tb_mem_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int NDUT = 2;

    logic clk = 1'b0;
    logic rst_n;
    logic [1:0]    req, wren, lock;
    logic [AW-1:0] addr  [2];
    logic [DW-1:0] wdata [2];
    logic [3:0]    bmask [2];

    logic [1:0]    gnt_w    [NDUT];
    logic [1:0]    rv_w     [NDUT];
    logic [DW-1:0] rd0_w    [NDUT];
    logic [DW-1:0] rd1_w    [NDUT];
    logic          en_w     [NDUT];
    logic          mwren_w  [NDUT];
    logic          busy_w   [NDUT];
    logic [AW-1:0] maddr_w  [NDUT];
    logic [DW-1:0] mwdata_w [NDUT];
    logic [3:0]    mbm_w    [NDUT];

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC3C3_5A5A;
    endfunction

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int unsigned LAT = g + 1;
        localparam int unsigned ML  = (g == 0) ? 8 : 3;

        logic m0_gnt, m1_gnt, m0_rv, m1_rv, en_l, wren_l, busy_l;
        logic [DW-1:0] m0_rd, m1_rd, mem_rd, wdata_l;
        logic [AW-1:0] addr_l;
        logic [3:0]    bm_l;
        logic [DW-1:0] line_q [LAT];

        mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT), .MAX_LOCK(ML)) u_dut (
            .i_clk       (clk),
            .i_reset     (rst_n),
            .i_m0_req    (req[0]),
            .i_m0_addr   (addr[0]),
            .i_m0_wdata  (wdata[0]),
            .i_m0_bmask  (bmask[0]),
            .i_m0_wren   (wren[0]),
            .i_m0_lock   (lock[0]),
            .o_m0_gnt    (m0_gnt),
            .o_m0_rvalid (m0_rv),
            .o_m0_rdata  (m0_rd),
            .i_m1_req    (req[1]),
            .i_m1_addr   (addr[1]),
            .i_m1_wdata  (wdata[1]),
            .i_m1_bmask  (bmask[1]),
            .i_m1_wren   (wren[1]),
            .i_m1_lock   (lock[1]),
            .o_m1_gnt    (m1_gnt),
            .o_m1_rvalid (m1_rv),
            .o_m1_rdata  (m1_rd),
            .o_mem_en    (en_l),
            .o_mem_addr  (addr_l),
            .o_mem_wdata (wdata_l),
            .o_mem_bmask (bm_l),
            .o_mem_wren  (wren_l),
            .i_mem_rdata (mem_rd),
            .o_busy      (busy_l)
        );

        // Memory returns a hash of the read address LAT cycles later, junk otherwise.
        always @(posedge clk) begin
            line_q[0] <= (en_l && !wren_l) ? mem_fn(addr_l) : $urandom;
            for (int i = 1; i < int'(LAT); i++) line_q[i] <= line_q[i-1];
        end
        assign mem_rd = line_q[LAT-1];

        assign gnt_w[g]    = {m1_gnt, m0_gnt};
        assign rv_w[g]     = {m1_rv, m0_rv};
        assign rd0_w[g]    = m0_rd;
        assign rd1_w[g]    = m1_rd;
        assign en_w[g]     = en_l;
        assign mwren_w[g]  = wren_l;
        assign busy_w[g]   = busy_l;
        assign maddr_w[g]  = addr_l;
        assign mwdata_w[g] = wdata_l;
        assign mbm_w[g]    = bm_l;
    end

    // Reference model: current owner (-1 = none), locked grants taken, last winner,
    // and a list of outstanding reads with the cycle their data is due.
    typedef struct {
        int          k;
        int          due;
        int          id;
        logic [31:0] addr;
    } rd_t;

    int  owner  [NDUT];
    int  held   [NDUT];
    int  last   [NDUT];
    int  lat_m  [NDUT] = '{1, 2};
    int  maxl_m [NDUT] = '{8, 3};
    rd_t pend [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NDUT; k++) begin
            owner[k] = -1;
            held[k]  = 0;
            last[k]  = 1;
        end
        pend.delete();
    endtask

    function automatic int winner(input int k);
        if (!rst_n) return -1;
        if (owner[k] >= 0) return req[owner[k]] ? owner[k] : -1;
        if (req[0] && req[1]) return 1 - last[k];
        if (req[0]) return 0;
        if (req[1]) return 1;
        return -1;
    endfunction

    task automatic check_model(input int k);
        int          w;
        logic [1:0]  eg, erv;
        logic [31:0] erd [2];
        logic        ebusy;
        w = winner(k);
        eg = 2'b00;
        erv = 2'b00;
        erd[0] = '0;
        erd[1] = '0;
        if (w >= 0) eg[w] = 1'b1;
        ebusy = (owner[k] >= 0);
        foreach (pend[i]) begin
            if (pend[i].k == k) begin
                if (pend[i].due == cyc) begin
                    erv[pend[i].id] = 1'b1;
                    erd[pend[i].id] = mem_fn(pend[i].addr);
                end
                if (pend[i].due >= cyc) ebusy = 1'b1;
            end
        end
        chk($sformatf("d%0d_gnt", k), 64'(gnt_w[k]), 64'(eg));
        chk($sformatf("d%0d_en", k), 64'(en_w[k]), 64'(w >= 0));
        chk($sformatf("d%0d_mwren", k), 64'(mwren_w[k]), 64'((w >= 0) ? wren[w] : 1'b0));
        chk($sformatf("d%0d_bmask", k), 64'(mbm_w[k]), 64'((w >= 0) ? bmask[w] : 4'h0));
        if (w >= 0 || !rst_n) begin
            chk($sformatf("d%0d_addr", k), 64'(maddr_w[k]), 64'((w >= 0) ? addr[w] : 32'h0));
            chk($sformatf("d%0d_wdata", k), 64'(mwdata_w[k]), 64'((w >= 0) ? wdata[w] : 32'h0));
        end
        chk($sformatf("d%0d_rvalid", k), 64'(rv_w[k]), 64'(erv));
        chk($sformatf("d%0d_rdata0", k), 64'(rd0_w[k]), 64'(erd[0]));
        chk($sformatf("d%0d_rdata1", k), 64'(rd1_w[k]), 64'(erd[1]));
        chk($sformatf("d%0d_busy", k), 64'(busy_w[k]), 64'(ebusy));
    endtask

    task automatic settle();
        @(negedge clk);
        if (!rst_n) model_reset();
        for (int k = 0; k < NDUT; k++) check_model(k);
    endtask

    task automatic advance();
        int  w;
        rd_t e;
        @(posedge clk);
        if (rst_n) begin
            for (int k = 0; k < NDUT; k++) begin
                w = winner(k);
                if (w >= 0) begin
                    if (!wren[w]) begin
                        e.k = k;
                        e.due = cyc + lat_m[k];
                        e.id = w;
                        e.addr = addr[w];
                        pend.push_back(e);
                    end
                    last[k] = w;
                end
                if (owner[k] < 0) begin
                    if (w >= 0 && lock[w] && maxl_m[k] > 1) begin
                        owner[k] = w;
                        held[k]  = 1;
                    end
                end else if (w < 0 || !lock[w] || held[k] + 1 >= maxl_m[k]) begin
                    owner[k] = -1;
                    held[k]  = 0;
                end else begin
                    held[k]++;
                end
            end
        end
        cyc++;
        for (int i = pend.size() - 1; i >= 0; i--) begin
            if (pend[i].due < cyc) pend.delete(i);
        end
        #1;
    endtask

    task automatic idle(input int n);
        req = 2'b00;
        lock = 2'b00;
        wren = 2'b00;
        for (int i = 0; i < n; i++) begin
            settle();
            advance();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req = 2'b11;
        wren = 2'b00;
        lock = 2'b00;
        for (int i = 0; i < 2; i++) begin
            addr[i] = '0;
            wdata[i] = '0;
            bmask[i] = 4'hF;
        end
        model_reset();
        #1;

        // Held in reset with both requesting: nothing may be granted.
        settle();
        chk("rst_gnt_a", 64'(gnt_w[0]), 64'(2'b00));
        chk("rst_gnt_b", 64'(gnt_w[1]), 64'(2'b00));
        chk("rst_en_a", 64'(en_w[0]), 64'(1'b0));
        advance();
        settle();
        advance();
        rst_n = 1'b1;

        // Tie after reset goes to m0, then m1; responses one cycle later.
        addr[0] = 32'h10;
        addr[1] = 32'h20;
        settle();
        chk("tie_gnt_a", 64'(gnt_w[0]), 64'(2'b01));
        chk("tie_addr_a", 64'(maddr_w[0]), 64'(32'h10));
        advance();
        req[0] = 1'b0;
        settle();
        chk("rr_gnt_a", 64'(gnt_w[0]), 64'(2'b10));
        chk("rv0_a", 64'(rv_w[0]), 64'(2'b01));
        chk("rd0_a", 64'(rd0_w[0]), 64'(mem_fn(32'h10)));
        advance();
        req[1] = 1'b0;
        settle();
        chk("rv1_a", 64'(rv_w[0]), 64'(2'b10));
        chk("rd1_a", 64'(rd1_w[0]), 64'(mem_fn(32'h20)));
        chk("rd0_zero_a", 64'(rd0_w[0]), 64'(32'h0));
        advance();
        idle(3);

        // m0 locked burst; m1 waits until the cycle after m0's unlocked grant.
        req = 2'b11;
        lock = 2'b01;
        addr[1] = 32'h40;
        for (int i = 0; i < 4; i++) begin
            addr[0] = 32'h100 + 32'(4 * i);
            if (i == 3) lock[0] = 1'b0;
            settle();
            chk($sformatf("lock0_gnt%0d_a", i), 64'(gnt_w[0]), 64'(2'b01));
            chk($sformatf("lock0_addr%0d_a", i), 64'(maddr_w[0]), 64'(addr[0]));
            advance();
        end
        req[0] = 1'b0;
        settle();
        chk("m1_after_unlock_a", 64'(gnt_w[0]), 64'(2'b10));
        advance();
        idle(3);

        // m1 holds lock; forced release after 8 locked grants, m0 wins next.
        req = 2'b10;
        lock = 2'b10;
        for (int i = 0; i < 9; i++) begin
            addr[1] = 32'h400 + 32'(4 * i);
            settle();
            chk($sformatf("own1_gnt%0d_a", i), 64'(gnt_w[0]), 64'((i < 8) ? 2'b10 : 2'b01));
            advance();
            req[0] = 1'b1;
        end
        idle(3);

        // Write: full command in grant cycle, no response afterwards.
        req = 2'b01;
        wren = 2'b01;
        addr[0] = 32'h2000;
        wdata[0] = 32'hDEAD_BEEF;
        bmask[0] = 4'hF;
        settle();
        chk("wr_gnt_a", 64'(gnt_w[0]), 64'(2'b01));
        chk("wr_en_a", 64'(en_w[0]), 64'(1'b1));
        chk("wr_wren_a", 64'(mwren_w[0]), 64'(1'b1));
        chk("wr_addr_a", 64'(maddr_w[0]), 64'(32'h2000));
        chk("wr_wdata_a", 64'(mwdata_w[0]), 64'(32'hDEAD_BEEF));
        chk("wr_bmask_a", 64'(mbm_w[0]), 64'(4'hF));
        advance();
        req = 2'b00;
        wren = 2'b00;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk($sformatf("wr_no_rv%0d_a", i), 64'(rv_w[0]), 64'(2'b00));
            chk($sformatf("idle_en%0d_a", i), 64'(en_w[0]), 64'(1'b0));
            advance();
        end

        // Reset one cycle after a read grant on the RD_LAT=2 instance.
        req = 2'b01;
        addr[0] = 32'h300;
        settle();
        chk("pre_rst_gnt_b", 64'(gnt_w[1]), 64'(2'b01));
        advance();
        req = 2'b11;
        rst_n = 1'b0;
        #1;
        chk("rst_async_busy_b", 64'(busy_w[1]), 64'(1'b0));
        chk("rst_async_gnt_b", 64'(gnt_w[1]), 64'(2'b00));
        settle();
        chk("rst_rv_b", 64'(rv_w[1]), 64'(2'b00));
        advance();
        settle();
        advance();
        rst_n = 1'b1;
        addr[1] = 32'h500;
        settle();
        chk("post_rst_tie_b", 64'(gnt_w[1]), 64'(2'b01));
        chk("post_rst_rv_b", 64'(rv_w[1]), 64'(2'b00));
        advance();
        req = 2'b00;
        settle();
        chk("post_rst_rv2_b", 64'(rv_w[1]), 64'(2'b00));
        advance();
        idle(3);

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 600; n++) begin
            rst_n = ($urandom_range(0, 99) >= 3);
            for (int i = 0; i < 2; i++) begin
                req[i]   = ($urandom_range(0, 9) != 0);
                lock[i]  = ($urandom_range(0, 3) != 0);
                wren[i]  = ($urandom_range(0, 2) == 0);
                addr[i]  = 32'($urandom_range(0, 255)) << 2;
                wdata[i] = $urandom;
                bmask[i] = 4'($urandom_range(0, 15));
            end
            settle();
            advance();
        end
        rst_n = 1'b1;
        idle(4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
